// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: upstream/downstream handshake and payload bundle for pipe_stage_skid.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 64,
  parameter int EXC_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_pc;
  logic [DATA_W-1:0] in_data;
  logic [EXC_W-1:0]  in_exc;
  logic              in_bd;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_pc8;
  logic [DATA_W-1:0] out_data;
  logic [EXC_W-1:0]  out_exc;
  logic              out_bd;
  modport slave (
    input  in_valid, in_pc, in_data, in_exc, in_bd, out_ready,
    output in_ready, out_valid, out_pc, out_pc8, out_data, out_exc, out_bd
  );
  modport master (
    output in_valid, in_pc, in_data, in_exc, in_bd, out_ready,
    input  in_ready, out_valid, out_pc, out_pc8, out_data, out_exc, out_bd
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry (MAIN + SKID) pipeline register with registered in_ready,
// flush and exception redirect.
module pipe_stage_skid #(
  parameter int          DATA_W   = 64,
  parameter int          EXC_W    = 5,
  parameter logic [31:0] PC_RESET = 32'hBFC00000,
  parameter logic [31:0] PC_EXC   = 32'hBFC00380,
  parameter logic [31:0] PC_INC   = 32'd8
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic req,
  pipe_stage_skid_if.slave bus
);
  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       pc8;
    logic [DATA_W-1:0] data;
    logic [EXC_W-1:0]  exc;
    logic              bd;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t r_state, w_state_nxt;
  entry_t r_main, r_skid, w_main_nxt, w_skid_nxt, w_new, w_exc;
  logic   r_in_ready, w_in_xfer, w_out_xfer;
  assign w_in_xfer  = bus.in_valid & r_in_ready;
  assign w_out_xfer = (r_state != EMPTY) & bus.out_ready;
  always_comb begin
    w_new      = '0;
    w_new.pc   = bus.in_pc;
    w_new.pc8  = bus.in_pc + PC_INC;
    w_new.data = bus.in_data;
    w_new.exc  = bus.in_exc;
    w_new.bd   = bus.in_bd;
    w_exc      = '0;
    w_exc.pc   = PC_EXC;
    w_exc.pc8  = PC_EXC + PC_INC;
  end
  // req outranks flush, which outranks any transfer; both drop a concurrent input beat
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (req) begin
      w_state_nxt = ONE;
      w_main_nxt  = w_exc;
      w_skid_nxt  = '0;
    end else if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else if (r_state == EMPTY) begin
      if (w_in_xfer) begin
        w_state_nxt = ONE;
        w_main_nxt  = w_new;
      end
    end else if (r_state == ONE) begin
      if (w_in_xfer && w_out_xfer) w_main_nxt = w_new;
      else if (w_in_xfer) begin
        w_state_nxt = TWO;
        w_skid_nxt  = w_new;
      end else if (w_out_xfer) w_state_nxt = EMPTY;
    end else if (w_out_xfer) begin
      w_state_nxt = ONE;
      w_main_nxt  = r_skid;
      w_skid_nxt  = '0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_main      <= '0;
      r_main.pc   <= PC_RESET;
      r_main.pc8  <= PC_RESET + PC_INC;
      r_skid      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != TWO);
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
    end
  end
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_state != EMPTY);
  assign bus.out_pc    = r_main.pc;
  assign bus.out_pc8   = r_main.pc8;
  assign bus.out_data  = r_main.data;
  assign bus.out_exc   = r_main.exc;
  assign bus.out_bd    = r_main.bd;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random checks of pipe_stage_skid against a queue-based
// model of the two-entry stage.
module tb_pipe_stage_skid;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [63:0] data;
    logic [4:0]  exc;
    logic        bd;
  } ent_t;
  logic clk = 1'b0;
  logic reset, flush, req;
  int   checks = 0, errors = 0;
  ent_t q[$];
  ent_t disp;
  pipe_stage_skid_if #(.DATA_W(64), .EXC_W(5)) bus ();
  pipe_stage_skid dut (.clk(clk), .reset(reset), .flush(flush), .req(req), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(bus.in_ready), 64'(q.size() != 2));
    chk("out_pc", 64'(bus.out_pc), 64'(disp.pc));
    chk("out_pc8", 64'(bus.out_pc8), 64'(disp.pc8));
    chk("out_data", bus.out_data, disp.data);
    chk("out_exc", 64'(bus.out_exc), 64'(disp.exc));
    chk("out_bd", 64'(bus.out_bd), 64'(disp.bd));
  endtask

  task automatic model_reset();
    q.delete();
    disp = '0;
    disp.pc = 32'hBFC00000;
    disp.pc8 = 32'hBFC00008;
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic [63:0] d,
                      input logic [4:0] e, input logic b, input logic ordy,
                      input logic fl, input logic rq);
    ent_t n;
    bit   inx, outx;
    @(negedge clk);
    bus.in_valid = v; bus.in_pc = pc; bus.in_data = d; bus.in_exc = e; bus.in_bd = b;
    bus.out_ready = ordy; flush = fl; req = rq;
    inx  = v && q.size() < 2;
    outx = q.size() > 0 && ordy;
    @(posedge clk);
    if (rq) begin
      n = '0; n.pc = 32'hBFC00380; n.pc8 = 32'hBFC00388;
      q.delete(); q.push_back(n); disp = n;
    end else if (fl) begin
      q.delete(); disp = '0;
    end else begin
      if (outx) void'(q.pop_front());
      if (inx) begin
        n.pc = pc; n.pc8 = pc + 32'd8; n.data = d; n.exc = e; n.bd = b;
        q.push_back(n);
      end
      if (q.size() > 0) disp = q[0];
    end
    #1 check_all();
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; req = 1'b0;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_data = '0; bus.in_exc = '0; bus.in_bd = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) reset = 1'b1;
    // back-to-back beats with out_ready held high
    step(1, 32'h100, 64'hA, 5'd0, 0, 1, 0, 0);
    step(1, 32'h104, 64'hB, 5'd0, 0, 1, 0, 0);
    step(1, 32'h108, 64'hC, 5'd0, 0, 1, 0, 0);
    step(0, 32'h0, 64'h0, 5'd0, 0, 1, 0, 0);
    // backpressure: fill to TWO, then drain in order
    step(1, 32'h200, 64'h1111, 5'd1, 0, 0, 0, 0);
    step(1, 32'h204, 64'h2222, 5'd2, 1, 0, 0, 0);
    step(1, 32'h208, 64'h3333, 5'd3, 0, 0, 0, 0);
    step(0, 32'h0, 64'h0, 5'd0, 0, 1, 0, 0);
    step(0, 32'h0, 64'h0, 5'd0, 0, 1, 0, 0);
    step(0, 32'h0, 64'h0, 5'd0, 0, 1, 0, 0);
    // req + flush + input in TWO
    step(1, 32'h300, 64'h5, 5'd1, 0, 0, 0, 0);
    step(1, 32'h304, 64'h6, 5'd1, 0, 0, 0, 0);
    step(1, 32'h308, 64'h7, 5'd1, 1, 0, 1, 1);
    step(0, 32'h0, 64'h0, 5'd0, 0, 1, 0, 0);
    // pc wrap, then flush zeroes everything
    step(1, 32'hFFFFFFFC, 64'hDEAD, 5'd4, 1, 0, 0, 0);
    step(0, 32'h0, 64'h0, 5'd0, 0, 0, 1, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, {$urandom, $urandom},
           5'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 39) == 0);
    // asynchronous reset mid-stream with no clock edge
    step(1, 32'h400, 64'h9, 5'd2, 0, 0, 0, 0);
    step(1, 32'h404, 64'hA, 5'd2, 0, 0, 0, 0);
    #2 reset = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk) reset = 1'b1;
    step(1, 32'h500, 64'hB, 5'd0, 0, 1, 0, 0);
    step(0, 32'h0, 64'h0, 5'd0, 0, 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 64: width of the opaque payload (instruction, BadVAddr and other sideband).
REQ-002 Parameter EXC_W, default 5: exception-code width.
REQ-003 Parameter PC_RESET, default 32'hBFC00000: PC held after reset.
REQ-004 Parameter PC_EXC, default 32'hBFC00380: PC loaded on exception request.
REQ-005 Parameter PC_INC, default 8: offset added to PC to form out_pc8.
REQ-006 The block SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-009 in_valid  in  1  upstream beat present.
REQ-010 in_ready  out  1  block can accept a beat.
REQ-011 in_pc  in  32  beat PC.
REQ-012 in_data  in  DATA_W  beat payload.
REQ-013 in_exc  in  EXC_W  beat exception code.
REQ-014 in_bd  in  1  beat is in a branch-delay slot.
REQ-015 flush  in  1  synchronous discard of all held beats.
REQ-016 req  in  1  synchronous exception redirect.
REQ-017 out_valid  out  1  output beat present.
REQ-018 out_ready  in  1  downstream accepts the output beat.
REQ-019 out_pc, out_pc8  out  32 each  held PC and PC+PC_INC.
REQ-020 out_data, out_exc, out_bd  out  DATA_W / EXC_W / 1  held payload fields.

Function
REQ-021 Storage SHALL be two entries: MAIN, which drives all out_* ports, and SKID; occupancy state is EMPTY, ONE or TWO.
REQ-022 An input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
REQ-023 in_ready SHALL be a registered signal equal to (state != TWO), with no combinational path from out_ready.
REQ-024 out_valid SHALL equal (state != EMPTY).
REQ-025 EMPTY + input transfer -> ONE; the beat enters MAIN and is visible on out_* the next cycle (latency 1).
REQ-026 ONE + input only -> TWO; the beat enters SKID.
REQ-027 ONE + output only -> EMPTY.
REQ-028 ONE + input and output -> ONE; the new beat replaces MAIN.
REQ-029 TWO + output transfer -> ONE; SKID moves to MAIN in the same edge.
REQ-030 TWO accepts no input.
REQ-031 Beats SHALL leave in arrival order, with no loss or duplication.
REQ-032 out_pc8 SHALL be captured together with its PC as (pc + PC_INC) mod 2^32; 32'hFFFFFFFC gives 32'h00000004.
REQ-033 req SHALL take priority over flush and over every transfer.
REQ-034 On req: state -> ONE; MAIN = {pc = PC_EXC, pc8 = PC_EXC + PC_INC, data = 0, exc = 0, bd = 0}; SKID is discarded; any concurrent input beat is dropped.
REQ-035 On flush without req: state -> EMPTY; MAIN and SKID fields are zeroed, including pc and pc8; any concurrent input beat is dropped.
REQ-036 In the cycle after req or flush, in_ready SHALL be 1.
REQ-037 Held fields SHALL NOT change while out_valid = 1 and out_ready = 0, except on req or flush.

Reset
REQ-038 While reset = 0, asynchronously: state = EMPTY, out_valid = 0, in_ready = 1, out_pc = PC_RESET, out_pc8 = PC_RESET + PC_INC, out_data = 0, out_exc = 0, out_bd = 0; SKID is zeroed.
REQ-039 Deassertion of reset SHALL take effect synchronously on the first rising clk edge after reset goes to 1.
REQ-040 Assertion of reset mid-operation SHALL discard all beats immediately, without waiting for clk.

Verification
REQ-041 Reset low mid-stream, no clk edge -> out_valid = 0 and out_pc = 32'hBFC00000 immediately; out_pc8 = 32'hBFC00008.
REQ-042 out_ready held at 1, send 3 back-to-back beats with pc 0x100 / 0x104 / 0x108 -> out_pc shows 0x100, 0x104, 0x108 on consecutive cycles, each one cycle after its input, with out_pc8 = 0x108 / 0x10C / 0x110.
REQ-043 out_ready = 0, send beats A and B -> in_ready = 0 after B; set out_ready = 1 -> A then B are delivered, in_ready returns to 1 one cycle after A leaves.
REQ-044 State TWO, assert req and flush together with in_valid = 1 -> next cycle: out_valid = 1, out_pc = 32'hBFC00380, out_pc8 = 32'hBFC00388, data, exc and bd = 0, the input beat is absent, and out_ready = 1 next yields EMPTY.
REQ-045 Beat with pc = 32'hFFFFFFFC, exc = 5'd4, bd = 1 -> out_pc8 = 32'h00000004, out_exc = 4, out_bd = 1; then flush -> out_valid = 0 and all fields are 0.
